// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the memory responder slice.
//   byte_t              one storage byte
//   word_bytes_t        four byte lanes, big-endian (lane 0 = bits 31:24)
//   mem_state_e         responder FSM states
//   MEM_SIZE_DEFAULT    default storage size in bytes
//   MEM_LATENCY_DEFAULT default request-to-completion latency in cycles
package mem_pkg;

    typedef logic [7:0] byte_t;
    typedef byte_t [0:3] word_bytes_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mem_state_e;

    localparam int unsigned MEM_SIZE_DEFAULT    = 65536;
    localparam int unsigned MEM_LATENCY_DEFAULT = 4;

endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array: SIZE-byte backing store, word-wide access.
//   clk_i    clock, rising edge
//   we_i     write strobe; writes all four lanes of wdata_i at widx_i
//   widx_i   word index (byte address / 4)
//   wdata_i  write data, lane k goes to byte widx_i*4+k
//   rdata_o  combinational read of the four bytes at widx_i
// Contents are never reset.
module mem_byte_array
    import mem_pkg::*;
#(
    parameter int unsigned SIZE = MEM_SIZE_DEFAULT,
    localparam int unsigned ADDR_BITS = $clog2(SIZE),
    localparam int unsigned WIDX_W    = (ADDR_BITS > 2) ? ADDR_BITS - 2 : 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [WIDX_W-1:0] widx_i,
    input  word_bytes_t       wdata_i,
    output word_bytes_t       rdata_o
);

    byte_t mem_q [SIZE];

    // The size cast only trims anything when SIZE=4 (a single word).
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned k = 0; k < 4; k++) begin
                mem_q[ADDR_BITS'({widx_i, k[1:0]})] <= wdata_i[k];
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            rdata_o[k] = mem_q[ADDR_BITS'({widx_i, k[1:0]})];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the data-cache refill/write-back
// interface. Accepts one word request while idle, completes it LATENCY
// cycles later with a one-cycle done pulse.
//   clk           sole clock, rising edge
//   reset         asynchronous, active-high
//   req           request strobe, sampled only while ready=1
//   write_en      1 = write, 0 = read, sampled with req
//   address       byte address, wraps modulo SIZE
//   mem_data_in   write data (4 big-endian byte lanes)
//   mem_data_out  read data, held until the next read completes
//   ready         idle and able to accept
//   done          one-cycle completion pulse
//   error         misalignment flag
// Optional feature: define MEM_RESPONDER_ALIGN_CHECK_EN to reject requests
// with address[1:0] != 0 (done at T0+1 with error=1, no access).
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned SIZE    = MEM_SIZE_DEFAULT,
    parameter int unsigned LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        write_en,
    input  logic [31:0] address,
    input  word_bytes_t mem_data_in,
    output word_bytes_t mem_data_out,
    output logic        ready,
    output logic        done,
    output logic        error
);

    localparam int unsigned ADDR_BITS = $clog2(SIZE);
    localparam int unsigned WIDX_W    = (ADDR_BITS > 2) ? ADDR_BITS - 2 : 1;
    localparam int unsigned CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic              we_q, we_d;
    word_bytes_t       wdata_q, wdata_d;
    word_bytes_t       rdata_q, rdata_d;

    logic              accept, access, mem_we, rd_load;
    logic              misaligned, skip;
    logic [WIDX_W-1:0] widx_in;
    word_bytes_t       mem_rdata;

    // Dropping the two byte-offset bits and truncating gives the wrap modulo SIZE.
    assign widx_in = WIDX_W'(address >> 2);

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    logic miss_q, miss_d;
    logic err_q, err_d;

    assign misaligned = |address[1:0];
    assign skip       = miss_q;
    assign error      = err_q;

    always_comb begin
        miss_d = miss_q;
        err_d  = err_q;
        if (accept) begin
            miss_d = misaligned;
            err_d  = 1'b0;
        end else if (access && miss_q) begin
            err_d  = 1'b1;
        end
    end
`else
    assign misaligned = 1'b0;
    assign skip       = 1'b0;
    assign error      = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = BUSY;
            BUSY:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs and access strobes
    always_comb begin
        ready   = (state_q == IDLE);
        done    = (state_q == DONE);
        accept  = (state_q == IDLE) && req;
        access  = (state_q == BUSY) && (cnt_q == '0);
        mem_we  = access && we_q && !skip;
        rd_load = access && !we_q && !skip;
    end

    // Request latches and latency counter. A misaligned request loads 0 so it
    // finishes on the very next edge, matching the LATENCY=1 timing.
    always_comb begin
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (accept) begin
            widx_d  = widx_in;
            we_d    = write_en;
            wdata_d = mem_data_in;
            cnt_d   = misaligned ? '0 : CNT_INIT;
        end else if ((state_q == BUSY) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (rd_load) begin
            rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            widx_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
            miss_q  <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
            miss_q  <= miss_d;
            err_q   <= err_d;
`endif
        end
    end

    assign mem_data_out = rdata_q;

    mem_byte_array #(
        .SIZE (SIZE)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .widx_i  (widx_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven bench for mem_responder with a read-data
// scoreboard. Three instances: LATENCY=4/SIZE=64K, LATENCY=1/SIZE=256,
// LATENCY=7/SIZE=256.
module tb_mem_responder;
    import mem_pkg::*;

    logic        clk;
    logic        reset;
    logic [2:0]  req_v;
    logic        write_en;
    logic [31:0] address;
    word_bytes_t mem_data_in;
    word_bytes_t rd0, rd1, rd2;
    logic [2:0]  ready_v, done_v, error_v;

    int n_chk;
    int n_fail;

    logic [31:0] exp_q [$];
    logic [31:0] last_rd [3];

    typedef struct {
        int          sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;  // write data, or expected read data
    } vec_t;

    vec_t tbl [$];

    mem_responder #(.SIZE(65536), .LATENCY(4)) u_dut0 (
        .clk(clk), .reset(reset), .req(req_v[0]), .write_en(write_en),
        .address(address), .mem_data_in(mem_data_in), .mem_data_out(rd0),
        .ready(ready_v[0]), .done(done_v[0]), .error(error_v[0])
    );

    mem_responder #(.SIZE(256), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req_v[1]), .write_en(write_en),
        .address(address), .mem_data_in(mem_data_in), .mem_data_out(rd1),
        .ready(ready_v[1]), .done(done_v[1]), .error(error_v[1])
    );

    mem_responder #(.SIZE(256), .LATENCY(7)) u_dut2 (
        .clk(clk), .reset(reset), .req(req_v[2]), .write_en(write_en),
        .address(address), .mem_data_in(mem_data_in), .mem_data_out(rd2),
        .ready(ready_v[2]), .done(done_v[2]), .error(error_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_of(input int sel);
        case (sel)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    function automatic int lat_of(input int sel);
        case (sel)
            0:       return 4;
            1:       return 1;
            default: return 7;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One request on instance sel; done must arrive exactly lat edges after acceptance.
    task automatic transact(input int sel, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input int lat, input logic exp_err,
                            input bit hold);
        int n;
        bit seen;
        int early_ready;
        logic [31:0] exp_rd;
        @(negedge clk);
        check("ready_idle", {31'd0, ready_v[sel]}, 32'd1);
        if (!we) exp_q.push_back(d);
        req_v       = '0;
        req_v[sel]  = 1'b1;
        write_en    = we;
        address     = a;
        mem_data_in = d;
        @(posedge clk);
        #1;
        // Disturb the inputs: only the latched copy may be used.
        if (hold) begin
            address     = a + 32'd4;
            mem_data_in = ~d;
        end else begin
            req_v       = '0;
            write_en    = ~we;
            address     = ~a;
            mem_data_in = ~d;
        end
        early_ready = ready_v[sel] ? 1 : 0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < lat + 5) begin
            @(posedge clk);
            #1;
            n++;
            if (done_v[sel]) seen = 1'b1;
            else if (ready_v[sel]) early_ready++;
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
            if (!we) void'(exp_q.pop_front());
            req_v = '0;
        end else begin
            check("done_latency", n, lat);
            check("ready_at_done", {31'd0, ready_v[sel]}, 32'd0);
            check("ready_early", early_ready, 32'd0);
            check("error_at_done", {31'd0, error_v[sel]}, {31'd0, exp_err});
            if (!we) begin
                exp_rd = exp_q.pop_front();
                check("read_data", rd_of(sel), exp_rd);
                last_rd[sel] = exp_rd;
            end else begin
                check("data_out_hold", rd_of(sel), last_rd[sel]);
            end
            req_v = '0;
            @(posedge clk);
            #1;
            check("done_pulse", {31'd0, done_v[sel]}, 32'd0);
            check("ready_back", {31'd0, ready_v[sel]}, 32'd1);
        end
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        reset       = 1'b1;
        req_v       = '0;
        write_en    = 1'b0;
        address     = '0;
        mem_data_in = '0;
        for (int i = 0; i < 3; i++) last_rd[i] = '0;

        tbl.push_back('{0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF});
        tbl.push_back('{0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF});
        tbl.push_back('{0, 1'b1, 32'h0001_0100, 32'h1122_3344});
        tbl.push_back('{0, 1'b0, 32'h0000_0100, 32'h1122_3344});
        tbl.push_back('{0, 1'b1, 32'h0000_0204, 32'hCAFE_F00D});
        tbl.push_back('{0, 1'b0, 32'hFFFF_0204, 32'hCAFE_F00D});
        tbl.push_back('{0, 1'b1, 32'h0000_0200, 32'h0102_0304});
        tbl.push_back('{0, 1'b0, 32'h0000_0200, 32'h0102_0304});
        tbl.push_back('{0, 1'b1, 32'h0000_0404, 32'hA5A5_A5A5});
        tbl.push_back('{1, 1'b1, 32'h0000_0010, 32'h0BAD_F00D});
        tbl.push_back('{1, 1'b0, 32'h0000_0010, 32'h0BAD_F00D});
        tbl.push_back('{1, 1'b1, 32'h0000_01F4, 32'h7654_3210});
        tbl.push_back('{1, 1'b0, 32'h0000_00F4, 32'h7654_3210});
        tbl.push_back('{2, 1'b1, 32'h0000_0020, 32'hFEED_FACE});
        tbl.push_back('{2, 1'b0, 32'h0000_0020, 32'hFEED_FACE});
        tbl.push_back('{2, 1'b0, 32'h0000_0120, 32'hFEED_FACE});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_ready", {31'd0, ready_v[i]}, 32'd1);
            check("rst_done", {31'd0, done_v[i]}, 32'd0);
            check("rst_error", {31'd0, error_v[i]}, 32'd0);
            check("rst_data", rd_of(i), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            transact(tbl[i].sel, tbl[i].we, tbl[i].addr, tbl[i].data,
                     lat_of(tbl[i].sel), 1'b0, 1'b0);
        end

        // req held high with changing address/data during BUSY
        transact(0, 1'b1, 32'h0000_0400, 32'h1020_3040, 4, 1'b0, 1'b1);
        transact(0, 1'b0, 32'h0000_0400, 32'h1020_3040, 4, 1'b0, 1'b0);
        transact(0, 1'b0, 32'h0000_0404, 32'hA5A5_A5A5, 4, 1'b0, 1'b0);

        // Reset two edges into a write: outputs reset at once, write discarded
        @(negedge clk);
        req_v       = 3'b001;
        write_en    = 1'b1;
        address     = 32'h0000_0200;
        mem_data_in = 32'hAABB_CCDD;
        @(posedge clk);
        #1;
        req_v = '0;
        repeat (2) @(posedge clk);
        #1;
        check("busy_ready", {31'd0, ready_v[0]}, 32'd0);
        reset = 1'b1;
        #1;
        check("abort_ready", {31'd0, ready_v[0]}, 32'd1);
        check("abort_done", {31'd0, done_v[0]}, 32'd0);
        check("abort_error", {31'd0, error_v[0]}, 32'd0);
        check("abort_data", rd_of(0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) last_rd[i] = '0;
        transact(0, 1'b0, 32'h0000_0200, 32'h0102_0304, 4, 1'b0, 1'b0);

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        transact(0, 1'b1, 32'h0000_0102, 32'h1234_5678, 1, 1'b1, 1'b0);
        @(negedge clk);
        check("error_held", {31'd0, error_v[0]}, 32'd1);
        transact(0, 1'b0, 32'h0000_0100, 32'h1122_3344, 4, 1'b0, 1'b0);
`else
        transact(0, 1'b1, 32'h0000_030A, 32'h5566_7788, 4, 1'b0, 1'b0);
        transact(0, 1'b0, 32'h0000_0308, 32'h5566_7788, 4, 1'b0, 1'b0);
`endif

        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
